// File: rtl/status_flag_scheduler_pkg.sv
// status_flag_scheduler_pkg: condition codes, flag indices and FSM encoding shared by the scheduler.
// rev 1.0
`default_nettype none

package status_flag_scheduler_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] PEND_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/status_flag_scheduler_cond_check.sv
// status_flag_scheduler_cond_check: ARM condition-code evaluation on {N,Z,C,V}.
// rev 1.0
`default_nettype none

module status_flag_scheduler_cond_check
  import status_flag_scheduler_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/status_flag_scheduler.sv
// status_flag_scheduler: flag-hazard stall, in-flight setter count and status-register write arbitration.
// rev 1.0
`default_nettype none

module status_flag_scheduler
  import status_flag_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] flags_cur,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_sets_flags,
  input  logic       advance,
  input  logic       flush,
  input  logic       ex_update,
  input  logic [3:0] ex_flags,
  input  logic       msr_req,
  input  logic [3:0] msr_data,
  output logic [3:0] sr_input,
  output logic       sr_update,
  output logic       cond_pass,
  output logic       stall,
  output logic       msr_ack
);

  logic [1:0] pend_cnt;
  logic [3:0] msr_hold;
  fsm_state_t state;
  fsm_state_t state_nxt;
  logic       setter_issue;
  logic       drain_ok;

  status_flag_scheduler_cond_check u_cond_check (
    .cond  (id_cond),
    .flags (flags_cur),
    .pass  (cond_pass)
  );

  // Conditional instructions wait until every in-flight setter has committed.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      stall = id_valid &&
              ((id_cond != COND_AL && (pend_cnt != 2'd0 || ex_update)) ||
               (id_sets_flags && pend_cnt == PEND_MAX) ||
               (state != ST_IDLE && (id_cond != COND_AL || id_sets_flags)));
    end
  end

  assign setter_issue = id_valid && id_sets_flags && advance && !stall;
  assign drain_ok     = (pend_cnt == 2'd0) && !ex_update;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= 2'd0;
    end else if (flush) begin
      pend_cnt <= 2'd0;
    end else if (setter_issue && !ex_update) begin
      pend_cnt <= pend_cnt + 2'd1;
    end else if (!setter_issue && ex_update && pend_cnt != 2'd0) begin
      pend_cnt <= pend_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      msr_hold <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && msr_req) begin
        msr_hold <= msr_data;
      end
    end
  end

  // The ALU commit always wins the register port; a pending software write just waits.
  always_comb begin
    state_nxt = state;
    msr_ack   = 1'b0;
    sr_update = 1'b0;
    sr_input  = 4'd0;
    case (state)
      ST_IDLE:  if (msr_req) state_nxt = drain_ok ? ST_WRITE : ST_DRAIN;
      ST_DRAIN: if (drain_ok) state_nxt = ST_WRITE;
      ST_WRITE: if (!ex_update) state_nxt = ST_ACK;
      ST_ACK: begin
        msr_ack   = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
    if (ex_update) begin
      sr_update = 1'b1;
      sr_input  = ex_flags;
    end else if (state == ST_WRITE) begin
      sr_update = 1'b1;
      sr_input  = msr_hold;
    end
    if (rst) begin
      sr_update = 1'b0;
      sr_input  = 4'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_status_flag_scheduler.sv
// tb_status_flag_scheduler: scoreboard bench for status_flag_scheduler.
// rev 1.0
`default_nettype none

module tb_status_flag_scheduler;
  import status_flag_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] flags_cur;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_sets_flags;
  logic       advance;
  logic       flush;
  logic       ex_update;
  logic [3:0] ex_flags;
  logic       msr_req;
  logic [3:0] msr_data;
  logic [3:0] sr_input;
  logic       sr_update;
  logic       cond_pass;
  logic       stall;
  logic       msr_ack;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       su;
    logic [3:0] si;
    logic       st;
    logic       ak;
    int         pend;
    int         cp;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  status_flag_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .flags_cur     (flags_cur),
    .id_valid      (id_valid),
    .id_cond       (id_cond),
    .id_sets_flags (id_sets_flags),
    .advance       (advance),
    .flush         (flush),
    .ex_update     (ex_update),
    .ex_flags      (ex_flags),
    .msr_req       (msr_req),
    .msr_data      (msr_data),
    .sr_input      (sr_input),
    .sr_update     (sr_update),
    .cond_pass     (cond_pass),
    .stall         (stall),
    .msr_ack       (msr_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy & !z;
      4'h9: return !cy | z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z & (n == v);
      4'hD: return z | (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    id_valid = 0; id_cond = COND_AL; id_sets_flags = 0; advance = 0; flush = 0;
    ex_update = 0; ex_flags = 4'd0; msr_req = 0; msr_data = 4'd0; flags_cur = 4'd0;
  endtask

  task automatic expect_cycle(input string tag, input logic su, input logic [3:0] si,
                              input logic st, input logic ak, input int pend, input int cp);
    exp_t e;
    e.su = su; e.si = si; e.st = st; e.ak = ak; e.pend = pend; e.cp = cp;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Outputs settle by the falling edge; inputs change 1 after the rising edge.
  task automatic tick();
    exp_t  e;
    string t;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".sr_update"}, int'(sr_update), int'(e.su));
      check({t, ".sr_input"}, int'(sr_input), int'(e.si));
      check({t, ".stall"}, int'(stall), int'(e.st));
      check({t, ".msr_ack"}, int'(msr_ack), int'(e.ak));
      if (e.pend >= 0) check({t, ".pend_cnt"}, int'(dut.pend_cnt), e.pend);
      if (e.cp >= 0) check({t, ".cond_pass"}, int'(cond_pass), e.cp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_setter(input string tag, input int pend_now);
    id_valid = 1; id_sets_flags = 1; id_cond = COND_AL; advance = 1;
    expect_cycle(tag, 0, 4'd0, 0, 0, pend_now, -1);
    tick();
  endtask

  initial begin
    idle_inputs();
    #1 rst = 1;
    id_valid = 1; id_cond = COND_EQ; ex_update = 1; ex_flags = 4'b1001; msr_req = 1;
    #3;
    check("rst.sr_update", int'(sr_update), 0);
    check("rst.sr_input", int'(sr_input), 0);
    check("rst.stall", int'(stall), 0);
    check("rst.msr_ack", int'(msr_ack), 0);
    check("rst.pend_cnt", int'(dut.pend_cnt), 0);
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();

    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        id_cond = 4'(c); flags_cur = 4'(f);
        #1;
        check($sformatf("cond.c%0d.f%0d", c, f), int'(cond_pass), int'(ref_cond(4'(c), 4'(f))));
      end
    end
    idle_inputs();
    @(posedge clk); #1;

    // flag setter followed by a dependent EQ
    issue_setter("hz.adds", 0);
    id_sets_flags = 0; id_cond = COND_EQ; advance = 1;
    expect_cycle("hz.wait", 0, 4'd0, 1, 0, 1, -1); tick();
    ex_update = 1; ex_flags = 4'b0100;
    expect_cycle("hz.commit", 1, 4'b0100, 1, 0, 1, -1); tick();
    ex_update = 0; flags_cur = 4'b0100;
    expect_cycle("hz.go", 0, 4'd0, 0, 0, 0, 1); tick();
    id_valid = 0; flags_cur = 4'b0000;
    expect_cycle("hz.z0", 0, 4'd0, 0, 0, 0, 0); tick();
    idle_inputs();

    // saturate the pending counter
    issue_setter("sat.s1", 0);
    issue_setter("sat.s2", 1);
    issue_setter("sat.s3", 2);
    expect_cycle("sat.s4", 0, 4'd0, 1, 0, 3, -1); tick();
    expect_cycle("sat.hold", 0, 4'd0, 1, 0, 3, -1); tick();
    ex_update = 1; ex_flags = 4'b0001;
    expect_cycle("sat.ex", 1, 4'b0001, 1, 0, 3, -1); tick();
    ex_update = 0;
    expect_cycle("sat.free", 0, 4'd0, 0, 0, 2, -1); tick();
    id_valid = 0;
    expect_cycle("sat.full", 0, 4'd0, 0, 0, 3, -1); tick();
    ex_update = 1; ex_flags = 4'b0010;
    for (int p = 3; p >= 0; p--) begin
      expect_cycle($sformatf("sat.drain%0d", p), 1, 4'b0010, 0, 0, p, -1); tick();
    end
    ex_update = 0;
    expect_cycle("sat.floor", 0, 4'd0, 0, 0, 0, -1); tick();
    idle_inputs();

    // software write with nothing in flight
    msr_req = 1; msr_data = 4'b1010;
    expect_cycle("msr.req", 0, 4'd0, 0, 0, 0, -1); tick();
    id_valid = 1; id_cond = COND_EQ; advance = 0;
    expect_cycle("msr.write", 1, 4'b1010, 1, 0, 0, -1); tick();
    id_valid = 0;
    expect_cycle("msr.ack", 0, 4'd0, 0, 1, 0, -1); tick();
    msr_req = 0;
    expect_cycle("msr.done", 0, 4'd0, 0, 0, 0, -1); tick();
    idle_inputs();

    // software write behind two setters
    issue_setter("dr.s1", 0);
    issue_setter("dr.s2", 1);
    idle_inputs();
    msr_req = 1; msr_data = 4'b0110;
    expect_cycle("dr.req", 0, 4'd0, 0, 0, 2, -1); tick();
    ex_update = 1; ex_flags = 4'b1000;
    expect_cycle("dr.ex1", 1, 4'b1000, 0, 0, 2, -1); tick();
    ex_flags = 4'b0010;
    expect_cycle("dr.ex2", 1, 4'b0010, 0, 0, 1, -1); tick();
    ex_update = 0;
    expect_cycle("dr.empty", 0, 4'd0, 0, 0, 0, -1); tick();
    ex_update = 1; ex_flags = 4'b0011;
    expect_cycle("dr.aluwins", 1, 4'b0011, 0, 0, 0, -1); tick();
    ex_update = 0;
    expect_cycle("dr.write", 1, 4'b0110, 0, 0, 0, -1); tick();
    expect_cycle("dr.ack", 0, 4'd0, 0, 1, 0, -1); tick();
    msr_req = 0;
    expect_cycle("dr.done", 0, 4'd0, 0, 0, 0, -1); tick();

    // flush alongside a commit
    issue_setter("fl.s1", 0);
    issue_setter("fl.s2", 1);
    idle_inputs();
    flush = 1; ex_update = 1; ex_flags = 4'b0100;
    expect_cycle("fl.commit", 1, 4'b0100, 0, 0, 2, -1); tick();
    flush = 0; ex_update = 0;
    expect_cycle("fl.cleared", 0, 4'd0, 0, 0, 0, -1); tick();

    // reset in the middle of a software write
    msr_req = 1; msr_data = 4'b1111;
    expect_cycle("rw.req", 0, 4'd0, 0, 0, 0, -1); tick();
    #1;
    check("rw.write.sr_update", int'(sr_update), 1);
    check("rw.write.sr_input", int'(sr_input), 15);
    rst = 1;
    #1;
    check("rw.rst.sr_update", int'(sr_update), 0);
    check("rw.rst.sr_input", int'(sr_input), 0);
    check("rw.rst.state", int'(dut.state), int'(ST_IDLE));
    check("rw.rst.msr_ack", int'(msr_ack), 0);
    @(posedge clk); #1;
    rst = 0; msr_req = 0;
    expect_cycle("rw.after1", 0, 4'd0, 0, 0, 0, -1); tick();
    expect_cycle("rw.after2", 0, 4'd0, 0, 0, 0, -1); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/status_flag_scheduler.md
STATUS_FLAG_SCHEDULER -- requirements
Module: status_flag_scheduler

Interface
REQ-001 The block SHALL have input clk, 1 bit: system clock; all state updates on posedge.
REQ-002 The block SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have input flags_cur, 4 bits: current status register contents {N,Z,C,V}, bits [3:0].
REQ-004 The block SHALL have input id_valid, 1 bit: the ID-stage instruction is valid.
REQ-005 The block SHALL have input id_cond, 4 bits: the ID-stage condition field.
REQ-006 The block SHALL have input id_sets_flags, 1 bit: the ID-stage instruction has its S bit set.
REQ-007 The block SHALL have input advance, 1 bit: the pipeline moves this cycle, so ID issues into EX.
REQ-008 The block SHALL have input flush, 1 bit: squash all uncommitted in-flight instructions.
REQ-009 The block SHALL have input ex_update, 1 bit: the EX-stage ALU commits flags this cycle.
REQ-010 The block SHALL have input ex_flags, 4 bits: ALU flag result {N,Z,C,V}.
REQ-011 The block SHALL have input msr_req, 1 bit: a software flag write is requested; held high until msr_ack.
REQ-012 The block SHALL have input msr_data, 4 bits: flag value for the software write.
REQ-013 The block SHALL have output sr_input, 4 bits: data driven to the status register.
REQ-014 The block SHALL have output sr_update, 1 bit: status register write enable, sampled by the register on negedge.
REQ-015 The block SHALL have output cond_pass, 1 bit: the ID instruction's condition holds on flags_cur.
REQ-016 The block SHALL have output stall, 1 bit: hold the ID stage.
REQ-017 The block SHALL have output msr_ack, 1 bit: one-cycle pulse when the software write has completed.

Function
REQ-018 cond_pass SHALL be combinational from id_cond and flags_cur, using standard ARM encodings: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
REQ-019 pend_cnt, 2 bits with range 0..3, SHALL count issued-but-uncommitted flag setters.
REQ-020 pend_cnt SHALL increment when id_valid&id_sets_flags&advance&!stall, and SHALL decrement on ex_update; when both occur in the same cycle it SHALL be unchanged.
REQ-021 pend_cnt SHALL never wrap; it SHALL be held at 3 because stall asserts for a flag setter when pend_cnt==3, and a decrement at 0 SHALL be ignored.
REQ-022 On flush, pend_cnt SHALL become 0 next cycle; an ex_update in the same cycle SHALL still commit its flags.
REQ-023 stall SHALL equal id_valid & ((id_cond!=AL & (pend_cnt!=0 | ex_update)) | (id_sets_flags & pend_cnt==3) | (state!=IDLE & (id_cond!=AL | id_sets_flags))).
REQ-024 The software-write FSM SHALL have the states IDLE, DRAIN, WRITE and ACK.
REQ-025 In IDLE, when msr_req is high, msr_data SHALL be captured into msr_hold; the FSM SHALL go to WRITE if pend_cnt==0 and !ex_update, otherwise to DRAIN.
REQ-026 In DRAIN, the FSM SHALL go to WRITE when pend_cnt==0 and !ex_update.
REQ-027 WRITE SHALL last 1 cycle and then go to ACK; if ex_update is high in WRITE, the FSM SHALL remain in WRITE.
REQ-028 ACK SHALL assert msr_ack for 1 cycle and then go to IDLE.
REQ-029 Flush SHALL NOT abort the FSM.
REQ-030 Write arbitration SHALL be combinational: ex_update gives sr_update=1 and sr_input=ex_flags; WRITE without ex_update gives sr_update=1 and sr_input=msr_hold; otherwise sr_update=0 and sr_input=0.
REQ-031 The ALU SHALL always win arbitration; ALU commit latency SHALL be 0 cycles.
REQ-032 Minimum msr_req-to-msr_ack latency SHALL be 2 cycles: IDLE, then WRITE, then ACK.

Reset
REQ-033 On rst, pend_cnt SHALL be 0, state SHALL be IDLE, msr_hold SHALL be 0 and msr_ack SHALL be 0.
REQ-034 During rst, outputs SHALL be sr_update=0, sr_input=0 and stall=0.
REQ-035 Reset mid-write SHALL discard the request with no ack; the requester SHALL re-issue.

Structure
REQ-036 A shared package SHALL hold: the condition-code constants (EQ..NV), FSM state encoding, flag bit indices N=3 Z=2 C=1 V=0, and PEND_MAX=3.
REQ-037 A combinational sub-module cond_check SHALL implement REQ-018.

Verification
REQ-038 Scenario: issue an ADDS with advance, then the next ID has EQ while ex_update is not yet seen -> stall=1 until the ex_update cycle has passed and pend_cnt=0; then cond_pass follows the new Z.
REQ-039 Scenario: issue three flag setters back-to-back with no ex_update -> pend_cnt=3; a fourth setter -> stall=1; one ex_update -> stall=0 next cycle.
REQ-040 Scenario: msr_req with msr_data=4'b1010 and pend_cnt=0 -> sr_update=1 and sr_input=1010 in cycle 1; msr_ack=1 in cycle 2.
REQ-041 Scenario: msr_req while pend_cnt=2 -> FSM in DRAIN; after two ex_update cycles -> WRITE; ALU flags written first, then msr_data.
REQ-042 Scenario: flush with pend_cnt=2 and ex_update=1, ex_flags=0100 -> sr_input=0100 and sr_update=1; pend_cnt=0 next cycle.
REQ-043 Scenario: rst asserted during WRITE -> sr_update=0 immediately, state IDLE, no msr_ack.
